mc_ctrl_fsm: RTL and testbench
==============================

Name: mc_ctrl_fsm

Overview:
- Control sequencer for the multi-cycle LoongArch core datapath (PC, IR, operand latches, ALU output latch, MDR, regfile).
- Steps each instruction through IF/ID/EXE/MEM/WB and issues one-cycle enable strobes to the datapath latches.
- Handshakes with variable-latency instruction and data SRAM ports (req/ready) and supports a clean halt between instructions.
- Sits between the decoder (class flags, branch resolution) and the datapath registers inside mycpu_top.

Parameters:
MAX_WAIT, 0, max cycles in IF or MEM waiting for ready; 0 disables the timeout
CNT_W, 32, width of the performance counters (feature only)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
halt_req  in  1  park in IDLE at the next instruction boundary
ifetch_req  out  1  instruction fetch request, held until accepted
ifetch_ready  in  1  instruction data valid this cycle
dmem_req  out  1  data access request, held until accepted
dmem_we  out  1  store qualifier; only high while dmem_req is high
dmem_ready  in  1  data access complete this cycle
is_branch  in  1  b/beq/bne class (no writeback)
is_load  in  1  ld.w class
is_store  in  1  st.w class
br_taken  in  1  datapath branch resolution, valid in ID
ir_we  out  1  latch the fetched instruction
opnd_we  out  1  latch rj/rkd operands and immediate
alu_we  out  1  latch the ALU result
mdr_we  out  1  latch load data
rf_we  out  1  regfile write enable
pc_we  out  1  update PC
pc_sel_br  out  1  PC source: 1 = branch target, 0 = pc+4
retire  out  1  one-cycle pulse per completed instruction
err  out  1  sticky handshake timeout
state  out  3  current state, for debug

Behaviour:
- State encoding: IDLE=0, IF=1, ID=2, EXE=3, MEM=4, WB=5. Encodings 6 and 7 are illegal and go to IDLE.
- Reset: state=IDLE, all outputs 0, br_taken_q=0, err=0.
- Reset mid-operation aborts immediately; any outstanding request is dropped. Memories must tolerate a dropped request.
- All strobe outputs are combinational from state and inputs. Each strobe is high for exactly one cycle per event.
- Flag priority: is_branch > is_load > is_store > ALU/jump-link. Load and store together is treated as load.
- Class flags are stable from ID until the next ir_we.
- IDLE: if !halt_req and !err, go to IF.
- IF:
  - ifetch_req=1.
  - On ifetch_ready: ir_we=1, go to ID. Otherwise hold.
- ID:
  - opnd_we=1; br_taken_q <= br_taken.
  - If is_branch: pc_we=1, pc_sel_br=br_taken, retire=1, then go to IDLE if halt_req, else IF.
  - Otherwise go to EXE.
- EXE: alu_we=1. If is_load or is_store, go to MEM; otherwise go to WB.
- MEM:
  - dmem_req=1, dmem_we=is_store.
  - On dmem_ready with a load: mdr_we=1, go to WB.
  - On dmem_ready with a store: pc_we=1, pc_sel_br=0, retire=1, then go to IDLE/IF by halt_req.
  - Otherwise hold.
- WB: rf_we=1, pc_we=1, pc_sel_br=br_taken_q (covers jirl/bl), retire=1, then go to IDLE/IF by halt_req.
- Minimum latency with ready in the first cycle:
  - branch: 2 cycles (IF, ID)
  - ALU: 4 cycles
  - store: 4 cycles
  - load: 5 cycles
- Wait counter: counts cycles spent in IF or MEM and clears on state exit.
  - If MAX_WAIT != 0 and the count reaches MAX_WAIT without ready: err <= 1, go to IDLE.
  - err is cleared only by reset. IDLE stays parked while err=1.
- halt_req is sampled only at retire and in IDLE. It never interrupts an instruction in flight.

Optional Feature:
- Macro MC_CTRL_PERF_EN.
- Defined:
  - Adds outputs cyc_cnt[CNT_W] (increments every non-reset cycle) and ret_cnt[CNT_W] (increments on retire).
  - Both counters reset to 0 and wrap modulo 2^CNT_W.
- Undefined: the ports and counters are absent; all other behaviour is unchanged.

Decomposition:
- Package mc_ctrl_pkg: state localparams/enum (STATE_W=3, S_IDLE..S_WB) and a PC-select constant (PC_SEQ=0, PC_BR=1).
- Optional sub-module mc_perf_cnt: the two counters, instantiated only under MC_CTRL_PERF_EN. The FSM otherwise stays a single module.

Test Plan:
1. Reset released at c0, ALU instruction, ifetch_ready always 1.
   - Expect: IDLE c0, ir_we c1, opnd_we c2, alu_we c3, rf_we+pc_we+retire c4 with pc_sel_br=0, ifetch_req again c5.
2. Load with dmem_ready arriving 3 cycles after MEM entry.
   - Expect: dmem_req high 3 cycles, dmem_we=0, mdr_we on the ready cycle, rf_we next cycle, exactly one retire.
3. beq in ID with br_taken=1, then bne with br_taken=0.
   - Expect: retire in ID both times, pc_sel_br=1 then 0, no alu_we/rf_we, 2 cycles per instruction.
4. Store, then jirl with br_taken=1.
   - Expect store: dmem_we=1 only while dmem_req=1, retire in MEM, no rf_we.
   - Expect jirl: WB with rf_we=1, pc_sel_br=1.
5. MAX_WAIT=4 with ifetch_ready held 0.
   - Expect: err=1 after 4 IF cycles, state=IDLE, no further ifetch_req until reset.
6. halt_req raised mid-EXE; reset asserted mid-MEM.
   - Expect halt case: retire occurs, state parks in IDLE; clearing halt_req leads to IF next cycle.
   - Expect reset case: all outputs 0 the next cycle, state=IDLE.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle core control sequencer:
// state encoding, PC source select values and the next-state choice made at retire.
package mc_ctrl_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE = 3'd0,
        S_IF   = 3'd1,
        S_ID   = 3'd2,
        S_EXE  = 3'd3,
        S_MEM  = 3'd4,
        S_WB   = 3'd5
    } state_t;

    localparam logic PC_SEQ = 1'b0;
    localparam logic PC_BR  = 1'b1;

    // halt_req is only honoured at an instruction boundary
    function automatic state_t retire_next(input logic halt_req);
        return halt_req ? S_IDLE : S_IF;
    endfunction

endpackage

// File: rtl/mc_perf_cnt.sv
// Free-running cycle counter and retired-instruction counter, both wrapping.
// Only instantiated when MC_CTRL_PERF_EN is defined.
module mc_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             retire,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] ret_cnt
);

    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_cnt <= '0;
            ret_cnt <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + CNT_W'(1);
            if (retire) begin
                ret_cnt <= ret_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Control sequencer for the multi-cycle core: IF/ID/EXE/MEM/WB with one-cycle datapath strobes.
// Define MC_CTRL_PERF_EN to add the cyc_cnt/ret_cnt performance counter outputs.
//
// state | meaning
// IDLE  | parked between instructions (halt_req or sticky err)
// IF    | instruction fetch, waiting on ifetch_ready
// ID    | operand latch; branches resolve and retire here
// EXE   | ALU result latch
// MEM   | data access, waiting on dmem_ready; stores retire here
// WB    | regfile write and PC update
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 0,
    parameter int CNT_W    = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         halt_req,
    output logic         ifetch_req,
    input  logic         ifetch_ready,
    output logic         dmem_req,
    output logic         dmem_we,
    input  logic         dmem_ready,
    input  logic         is_branch,
    input  logic         is_load,
    input  logic         is_store,
    input  logic         br_taken,
    output logic         ir_we,
    output logic         opnd_we,
    output logic         alu_we,
    output logic         mdr_we,
    output logic         rf_we,
    output logic         pc_we,
    output logic         pc_sel_br,
    output logic         retire,
    output logic         err,
    output logic [2:0]   state
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] ret_cnt
`endif
);

    localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LOAD = (MAX_WAIT > 0) ? WAIT_W'(MAX_WAIT - 1) : '0;

    state_t            state_q;
    state_t            state_d;
    logic              br_taken_q;
    logic              err_q;
    logic              err_set;
    logic              in_wait;
    logic              wait_tc;
    logic [WAIT_W-1:0] wait_cnt;

    assign state   = state_q;
    assign err     = err_q;
    assign in_wait = (state_q == S_IF) || (state_q == S_MEM);
    assign wait_tc = (MAX_WAIT != 0) && in_wait && (wait_cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            br_taken_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_ID) begin
                br_taken_q <= br_taken;
            end
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    // down-counter reloads whenever the wait state is left, so IF and MEM each get a full budget
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= WAIT_LOAD;
        end else if (!in_wait || (state_d != state_q)) begin
            wait_cnt <= WAIT_LOAD;
        end else if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        ifetch_req = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        ir_we      = 1'b0;
        opnd_we    = 1'b0;
        alu_we     = 1'b0;
        mdr_we     = 1'b0;
        rf_we      = 1'b0;
        pc_we      = 1'b0;
        pc_sel_br  = PC_SEQ;
        retire     = 1'b0;
        err_set    = 1'b0;
        // reset drops any outstanding request in the same cycle
        if (!reset) begin
            case (state_q)
                S_IDLE: begin
                    if (!halt_req && !err_q) begin
                        state_d = S_IF;
                    end
                end
                S_IF: begin
                    ifetch_req = 1'b1;
                    if (ifetch_ready) begin
                        ir_we   = 1'b1;
                        state_d = S_ID;
                    end else if (wait_tc) begin
                        err_set = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                S_ID: begin
                    opnd_we = 1'b1;
                    if (is_branch) begin
                        pc_we     = 1'b1;
                        pc_sel_br = br_taken ? PC_BR : PC_SEQ;
                        retire    = 1'b1;
                        state_d   = retire_next(halt_req);
                    end else begin
                        state_d = S_EXE;
                    end
                end
                S_EXE: begin
                    alu_we  = 1'b1;
                    state_d = (is_load || is_store) ? S_MEM : S_WB;
                end
                S_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = is_store && !is_load;
                    if (dmem_ready) begin
                        if (is_load) begin
                            mdr_we  = 1'b1;
                            state_d = S_WB;
                        end else begin
                            pc_we   = 1'b1;
                            retire  = 1'b1;
                            state_d = retire_next(halt_req);
                        end
                    end else if (wait_tc) begin
                        err_set = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                S_WB: begin
                    rf_we     = 1'b1;
                    pc_we     = 1'b1;
                    pc_sel_br = br_taken_q ? PC_BR : PC_SEQ;
                    retire    = 1'b1;
                    state_d   = retire_next(halt_req);
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

`ifdef MC_CTRL_PERF_EN
    mc_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_perf_cnt (
        .clk     (clk),
        .reset   (reset),
        .retire  (retire),
        .cyc_cnt (cyc_cnt),
        .ret_cnt (ret_cnt)
    );
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed self-checking bench for mc_ctrl_fsm (MAX_WAIT=4).
// Input vector bits: reset,halt,if_rdy,dm_rdy,br,ld,st,bt; output vector bits listed at obs.
module tb_mc_ctrl_fsm;

    logic clk = 1'b0;
    logic reset, halt_req, ifetch_ready, dmem_ready;
    logic is_branch, is_load, is_store, br_taken;
    logic ifetch_req, dmem_req, dmem_we, ir_we, opnd_we, alu_we, mdr_we;
    logic rf_we, pc_we, pc_sel_br, retire, err;
    logic [2:0] state;
`ifdef MC_CTRL_PERF_EN
    logic [31:0] cyc_cnt, ret_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    // 800 ifetch_req, 400 ir_we, 200 opnd_we, 100 alu_we, 080 dmem_req, 040 dmem_we,
    // 020 mdr_we, 010 rf_we, 008 pc_we, 004 pc_sel_br, 002 retire, 001 err
    wire [11:0] obs = {ifetch_req, ir_we, opnd_we, alu_we, dmem_req, dmem_we,
                       mdr_we, rf_we, pc_we, pc_sel_br, retire, err};

    mc_ctrl_fsm #(.MAX_WAIT(4), .CNT_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .halt_req     (halt_req),
        .ifetch_req   (ifetch_req),
        .ifetch_ready (ifetch_ready),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_ready   (dmem_ready),
        .is_branch    (is_branch),
        .is_load      (is_load),
        .is_store     (is_store),
        .br_taken     (br_taken),
        .ir_we        (ir_we),
        .opnd_we      (opnd_we),
        .alu_we       (alu_we),
        .mdr_we       (mdr_we),
        .rf_we        (rf_we),
        .pc_we        (pc_we),
        .pc_sel_br    (pc_sel_br),
        .retire       (retire),
        .err          (err),
        .state        (state)
`ifdef MC_CTRL_PERF_EN
        ,
        .cyc_cnt      (cyc_cnt),
        .ret_cnt      (ret_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic [7:0] v);
        {reset, halt_req, ifetch_ready, dmem_ready, is_branch, is_load, is_store, br_taken} = v;
    endtask

    task automatic do_reset();
        apply(8'h80);
        tick();
        tick();
        apply(8'h00);
    endtask

    task automatic test_reset();
        apply(8'hBF);
        tick();
        tick();
        #2;
        checks++;
        if (state !== 3'd0) begin
            failures++;
            $display("FAIL reset_state: got %0d want 0", state);
        end
        checks++;
        if (obs !== 12'h000) begin
            failures++;
            $display("FAIL reset_outputs: got %h want 000", obs);
        end
        apply(8'h00);
    endtask

    task automatic test_alu();
        logic [7:0]  in_v [6];
        logic [2:0]  st_v [6];
        logic [11:0] ob_v [6];
        in_v = '{8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20};
        st_v = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd1};
        ob_v = '{12'h000, 12'hC00, 12'h200, 12'h100, 12'h01A, 12'hC00};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            apply(in_v[i]);
            #2;
            checks++;
            if (state !== st_v[i]) begin
                failures++;
                $display("FAIL alu_state c%0d: got %0d want %0d", i, state, st_v[i]);
            end
            checks++;
            if (obs !== ob_v[i]) begin
                failures++;
                $display("FAIL alu_outputs c%0d: got %h want %h", i, obs, ob_v[i]);
            end
            tick();
        end
    endtask

    task automatic test_load();
        logic [7:0]  in_v [9];
        logic [2:0]  st_v [9];
        logic [11:0] ob_v [9];
        in_v = '{8'h24, 8'h24, 8'h24, 8'h24, 8'h24, 8'h24, 8'h34, 8'h24, 8'h24};
        st_v = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd5, 3'd1};
        ob_v = '{12'h000, 12'hC00, 12'h200, 12'h100, 12'h080, 12'h080, 12'h0A0, 12'h01A, 12'hC00};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            apply(in_v[i]);
            #2;
            checks++;
            if (state !== st_v[i]) begin
                failures++;
                $display("FAIL load_state c%0d: got %0d want %0d", i, state, st_v[i]);
            end
            checks++;
            if (obs !== ob_v[i]) begin
                failures++;
                $display("FAIL load_outputs c%0d: got %h want %h", i, obs, ob_v[i]);
            end
            tick();
        end
    endtask

    task automatic test_branch();
        logic [7:0]  in_v [6];
        logic [2:0]  st_v [6];
        logic [11:0] ob_v [6];
        in_v = '{8'h29, 8'h29, 8'h29, 8'h28, 8'h28, 8'h28};
        st_v = '{3'd0, 3'd1, 3'd2, 3'd1, 3'd2, 3'd1};
        ob_v = '{12'h000, 12'hC00, 12'h20E, 12'hC00, 12'h20A, 12'hC00};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            apply(in_v[i]);
            #2;
            checks++;
            if (state !== st_v[i]) begin
                failures++;
                $display("FAIL branch_state c%0d: got %0d want %0d", i, state, st_v[i]);
            end
            checks++;
            if (obs !== ob_v[i]) begin
                failures++;
                $display("FAIL branch_outputs c%0d: got %h want %h", i, obs, ob_v[i]);
            end
            tick();
        end
    endtask

    task automatic test_store_jirl();
        logic [7:0]  in_v [10];
        logic [2:0]  st_v [10];
        logic [11:0] ob_v [10];
        in_v = '{8'h22, 8'h22, 8'h22, 8'h22, 8'h32, 8'h21, 8'h21, 8'h20, 8'h20, 8'h20};
        st_v = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd1, 3'd2, 3'd3, 3'd5, 3'd1};
        ob_v = '{12'h000, 12'hC00, 12'h200, 12'h100, 12'h0CA,
                 12'hC00, 12'h200, 12'h100, 12'h01E, 12'hC00};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            apply(in_v[i]);
            #2;
            checks++;
            if (state !== st_v[i]) begin
                failures++;
                $display("FAIL store_jirl_state c%0d: got %0d want %0d", i, state, st_v[i]);
            end
            checks++;
            if (obs !== ob_v[i]) begin
                failures++;
                $display("FAIL store_jirl_outputs c%0d: got %h want %h", i, obs, ob_v[i]);
            end
            tick();
        end
    endtask

    task automatic test_halt();
        logic [7:0]  in_v [9];
        logic [2:0]  st_v [9];
        logic [11:0] ob_v [9];
        in_v = '{8'h20, 8'h20, 8'h20, 8'h60, 8'h60, 8'h60, 8'h60, 8'h20, 8'h20};
        st_v = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd0, 3'd0, 3'd0, 3'd1};
        ob_v = '{12'h000, 12'hC00, 12'h200, 12'h100, 12'h01A, 12'h000, 12'h000, 12'h000, 12'hC00};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            apply(in_v[i]);
            #2;
            checks++;
            if (state !== st_v[i]) begin
                failures++;
                $display("FAIL halt_state c%0d: got %0d want %0d", i, state, st_v[i]);
            end
            checks++;
            if (obs !== ob_v[i]) begin
                failures++;
                $display("FAIL halt_outputs c%0d: got %h want %h", i, obs, ob_v[i]);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_mem();
        logic [2:0]  st_v [6];
        logic [11:0] ob_v [6];
        st_v = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
        ob_v = '{12'h000, 12'hC00, 12'h200, 12'h100, 12'h080, 12'h080};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            apply(8'h24);
            #2;
            checks++;
            if (state !== st_v[i]) begin
                failures++;
                $display("FAIL rst_mem_state c%0d: got %0d want %0d", i, state, st_v[i]);
            end
            checks++;
            if (obs !== ob_v[i]) begin
                failures++;
                $display("FAIL rst_mem_outputs c%0d: got %h want %h", i, obs, ob_v[i]);
            end
            tick();
        end
        apply(8'hA4);
        #2;
        checks++;
        if (dmem_req !== 1'b0) begin
            failures++;
            $display("FAIL rst_mem_drop: dmem_req got %b want 0", dmem_req);
        end
        tick();
        #2;
        checks++;
        if (state !== 3'd0) begin
            failures++;
            $display("FAIL rst_mem_after_state: got %0d want 0", state);
        end
        checks++;
        if (obs !== 12'h000) begin
            failures++;
            $display("FAIL rst_mem_after_outputs: got %h want 000", obs);
        end
        apply(8'h24);
        tick();
        #2;
        checks++;
        if (state !== 3'd1) begin
            failures++;
            $display("FAIL rst_mem_restart: state got %0d want 1", state);
        end
    endtask

    task automatic test_timeout();
        logic [2:0]  st_v [8];
        logic [11:0] ob_v [8];
        st_v = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0};
        ob_v = '{12'h000, 12'h800, 12'h800, 12'h800, 12'h800, 12'h001, 12'h001, 12'h001};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            apply(8'h00);
            #2;
            checks++;
            if (state !== st_v[i]) begin
                failures++;
                $display("FAIL timeout_state c%0d: got %0d want %0d", i, state, st_v[i]);
            end
            checks++;
            if (obs !== ob_v[i]) begin
                failures++;
                $display("FAIL timeout_outputs c%0d: got %h want %h", i, obs, ob_v[i]);
            end
            tick();
        end
        do_reset();
        apply(8'h20);
        #2;
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL timeout_err_clear: got %b want 0", err);
        end
        tick();
        #2;
        checks++;
        if (state !== 3'd1) begin
            failures++;
            $display("FAIL timeout_resume: state got %0d want 1", state);
        end
    endtask

    initial begin
        apply(8'h80);
        test_reset();
        test_alu();
        test_load();
        test_branch();
        test_store_jirl();
        test_halt();
        test_reset_mid_mem();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
